instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction fetch stage, directly upstream of the instruction decoder.
//   - Holds the fetch PC and issues pipelined read requests to instruction memory.
//   - Buffers returned words in a small queue and presents {instruction, pc} to the decoder under valid/ready.
//   - Accepts PC redirects from the jump/branch path and discards stale in-flight words.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC fetched first after reset
//   FIFO_DEPTH  2              queue entries and max in-flight requests (power of 2, >=2)
// PORTS
//   clk              in   1   single clock, rising edge
//   rst_n            in   1   asynchronous, active-low reset
//   imem_req_valid   out  1   fetch request valid
//   imem_req_ready   in   1   memory accepts request
//   imem_req_addr    out  32  fetch address, word aligned
//   imem_rsp_valid   in   1   response valid; always accepted; in order; latency >=1
//   imem_rsp_data    in   32  returned instruction word
//   redirect_valid   in   1   take redirect_pc (jump/taken branch)
//   redirect_pc      in   32  new fetch target
//   instr_valid      out  1   instruction/instr_pc valid to decoder
//   instr_ready      in   1   decoder consumes head
//   instruction      out  32  instruction word; 32'h0000_0013 when !instr_valid
//   instr_pc         out  32  PC of instruction
//   fault_valid      out  1   misaligned-redirect fault (sticky)
//   fault_pc         out  32  offending redirect_pc
// BEHAVIOUR
//   - Reset (async): all outputs low except instruction=NOP.
//     fetch_pc=rsp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=BOOT.
//   - FSM: BOOT -(1 cycle, no request)-> FETCH; FETCH -(fault)-> HALT; HALT exits only by reset.
//   - Request: imem_req_valid = FETCH && !redirect_valid && (outstanding + q_count < FIFO_DEPTH).
//     imem_req_addr = fetch_pc. Handshake (valid&ready): fetch_pc += 4 (mod 2^32 wrap), outstanding+1.
//   - Response: outstanding-1. If drop_cnt>0: discard and decrement drop_cnt.
//     Else push {rsp_pc, data}, rsp_pc += 4. The credit check guarantees the queue never overflows.
//   - Output: registered queue head; min latency = rsp -> instr_valid next cycle.
//     Pop on instr_valid&instr_ready. Push and pop in the same cycle are legal at any fill level.
//     Output is held stable while valid&!ready.
//   - Redirect (highest priority), in the redirect cycle:
//     - queue flushed, including any same-cycle pop or push;
//     - no request issued; a response arriving that cycle is discarded;
//     - fetch_pc and rsp_pc load redirect_pc;
//     - drop_cnt <= drop_cnt + requests still outstanding after that cycle.
//     Back-to-back redirects accumulate correctly; the last one wins.
//   - Reset mid-operation: state is cleared immediately. The memory side must also be reset, so responses to pre-reset requests never return.
// CONFIGURATION
//   IFU_MISALIGN_FAULT_EN defined:
//     - redirect_valid with redirect_pc[1:0]!=0 -> fault_valid=1 and fault_pc=redirect_pc next cycle, state=HALT.
//     - Queue flushed, no further requests; instr_valid stays 0; in-flight responses are dropped.
//   IFU_MISALIGN_FAULT_EN undefined:
//     - redirect_pc[1:0] forced to 2'b00.
//     - fault_valid and fault_pc tied to 0; ports remain present.
// STRUCTURE
//   - Shared header inc/fetch_defs.v: FSM state codes (BOOT/FETCH/HALT, 2 bits), INSTR_NOP 32'h0000_0013, FETCH_RESET_PC default.
//   - Sub-module fetch_fifo: synchronous FIFO, params DEPTH/WIDTH=64.
//     Ports push, pop, flush, full, empty, count, din, dout. Flush has priority over push and pop.
//   - Counters (outstanding, drop_cnt) are $clog2(FIFO_DEPTH)+1 bits wide.
// TESTING
//   1. Reset, memory latency 1, ready=1 -> first request in cycle 2 at addr 0.
//      Decoder sees pc 0,4,8,... one per cycle after fill.
//   2. instr_ready=0 for 10 cycles -> at most 2 requests issued; head stays pc 0.
//      Release -> pcs 0,4,8 in order, none lost or duplicated.
//   3. Memory latency 3, redirect to 0x100 with 2 in flight -> both stale words dropped.
//      Next instr_pc is 0x100 with the word from addr 0x100.
//   4. Redirect in the same cycle as a response and a pop -> queue empty next cycle; stale response dropped.
//      Outstanding count returns to 0 with no leak.
//   5. imem_req_ready toggling 1/0 every cycle, fetch from 0xFFFF_FFF8 -> addresses F8, FC, 0 wrap.
//      Instruction stream intact.
//   6. IFU_MISALIGN_FAULT_EN, redirect_pc=0x102 -> fault_valid=1, fault_pc=0x102.
//      No further requests; instr_valid=0. Without the macro: fetch resumes at 0x100.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state codes, the NOP
// encoding, the default reset PC and the layout of a queued fetch entry.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} entries; flush beats push and pop,
// and a push into a full queue is accepted when a pop frees a slot in the same cycle.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues credit-limited pipelined reads, queues returned words
// and hands {instruction, pc} to the decoder. IFU_MISALIGN_FAULT_EN enables the misaligned-redirect fault.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        fault_valid,
  output logic [31:0] fault_pc
);
  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]   CREDITS = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc, rsp_pc, redir_pc_eff;
  logic [CNT_W-1:0] outstanding, outstanding_d, drop_cnt, q_count;
  logic             redir_act, misalign, req_fire, rsp_push, q_pop, q_full, q_empty;
  fetch_entry_t     q_din, q_dout;

  assign redir_act = redirect_valid && (state_q != ST_HALT);

`ifdef IFU_MISALIGN_FAULT_EN
  assign redir_pc_eff = redirect_pc;
  assign misalign     = redir_act && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid <= 1'b0;
      fault_pc    <= '0;
    end else if (misalign) begin
      fault_valid <= 1'b1;
      fault_pc    <= redirect_pc;
    end
  end
`else
  assign redir_pc_eff = redirect_pc & 32'hFFFF_FFFC;
  assign misalign     = 1'b0;
  assign fault_valid  = 1'b0;
  assign fault_pc     = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = misalign ? ST_HALT : ST_FETCH;
      ST_FETCH: if (misalign) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_HALT;
    endcase
  end

  // Credits cover both in-flight requests and queued words, so a response always has a slot.
  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_valid = !redirect_valid &&
                         (({1'b0, outstanding} + {1'b0, q_count}) < CREDITS);
        instr_valid    = !q_empty;
      end
      ST_BOOT:  instr_valid = !q_empty;
      default:  ;
    endcase
  end

  assign imem_req_addr = fetch_pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_push      = imem_rsp_valid && (drop_cnt == '0) && !redir_act &&
                         (state_q == ST_FETCH) && (!q_full || q_pop);
  assign q_pop         = instr_valid && instr_ready;
  assign outstanding_d = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
  assign q_din         = {rsp_pc, imem_rsp_data};

  // On a redirect every request still in flight is stale, so drop_cnt becomes the full outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_d;
      if (redir_act) begin
        fetch_pc <= redir_pc_eff;
        rsp_pc   <= redir_pc_eff;
        drop_cnt <= outstanding_d;
      end else begin
        if (req_fire) fetch_pc <= pc_incr(fetch_pc);
        if (rsp_push) rsp_pc   <= pc_incr(rsp_pc);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .pop   (q_pop),
    .flush (redir_act),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign instruction = instr_valid ? q_dout.instr : INSTR_NOP;
  assign instr_pc    = instr_valid ? q_dout.pc    : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a latency-configurable memory model plus a
// scoreboard of accepted fetches that is checked against every decoder pop.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  typedef struct packed { logic [31:0] addr; logic [31:0] due; } pend_t;
  typedef struct packed { logic [31:0] pc;   logic [31:0] w;   } exp_t;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;
  logic        fault_valid;
  logic [31:0] fault_pc;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .fault_valid(fault_valid), .fault_pc(fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] cyc, lat;
  logic        tog, rsp_driven;
  int          n_pass = 0, n_fail = 0, n_total = 0;
  int          n_req = 0, n_pop = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive the memory response, observe handshakes, score pops.
  task automatic step();
    pend_t p;
    exp_t  e;
    rsp_driven = 1'b0;
    if (tog) imem_req_ready = ~imem_req_ready;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
      rsp_driven = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      p.addr = imem_req_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
      e.pc = imem_req_addr;
      e.w  = mem_word(imem_req_addr);
      exp_q.push_back(e);
      req_log.push_back(imem_req_addr);
      n_req++;
    end
    if (redirect_valid) exp_q.delete();
    else if (instr_valid && instr_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_pc", instr_pc, e.pc);
        check("pop_instr", instruction, e.w);
        n_pop++;
      end
    end
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend.delete();
    exp_q.delete();
    req_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 32'd1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1, found;
    rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    tog = 1'b0; lat = 32'd1; cyc = '0; rsp_driven = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", instruction, INSTR_NOP);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fault_valid", 32'(fault_valid), 32'd0);
    @(negedge clk);

    // 1: latency 1 streaming
    do_reset();
    #1;
    check("boot_no_req", 32'(imem_req_valid), 32'd0);
    step();
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    n1 = n_pop;
    repeat (20) step();
    check("stream_pops", 32'(n_pop - n1 >= 8), 32'd1);

    // 2: decoder stall
    do_reset();
    instr_ready = 1'b0;
    n0 = n_req;
    repeat (10) step();
    check("stall_reqs", 32'(n_req - n0), 32'd2);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", instr_pc, 32'h0);
    check("stall_head_instr", instruction, mem_word(32'h0));
    instr_ready = 1'b1;
    n1 = n_pop;
    repeat (12) step();
    check("stall_drain", 32'(n_pop - n1 >= 3), 32'd1);

    // 3: latency 3, redirect with two in flight
    do_reset();
    lat = 32'd3;
    instr_ready = 1'b0;
    repeat (3) step();
    #1;
    check("t3_credit_full", 32'(imem_req_valid), 32'd0);
    check("t3_inflight", 32'(pend.size()), 32'd2);
    redirect_to(32'h100);
    for (int i = 0; i < 30 && !instr_valid; i++) step();
    check("t3_wait_valid", 32'(instr_valid), 32'd1);
    check("t3_redir_pc", instr_pc, 32'h100);
    check("t3_redir_instr", instruction, mem_word(32'h100));
    instr_ready = 1'b1;
    repeat (12) step();

    // 4: redirect together with a response and a pop
    do_reset();
    lat = 32'd1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (instr_valid && pend.size() > 0 && pend[0].due <= cyc) found = 1;
      else step();
    end
    check("t4_found", 32'(found), 32'd1);
    redirect_to(32'h200);
    check("t4_rsp_same_cycle", 32'(rsp_driven), 32'd1);
    check("t4_flushed", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;
    repeat (12) step();
    check("t4_no_inflight", 32'(pend.size()), 32'd0);
    check("t4_queue_fill", 32'(exp_q.size()), 32'd2);
    check("t4_head_pc", instr_pc, 32'h200);
    instr_ready = 1'b1;
    repeat (8) step();

    // 5: wrap with toggling ready
    req_log.delete();
    redirect_to(32'hFFFF_FFF8);
    tog = 1'b1;
    n1 = n_pop;
    repeat (24) step();
    tog = 1'b0;
    imem_req_ready = 1'b1;
    check("wrap_nreq", 32'(req_log.size() >= 3), 32'd1);
    if (req_log.size() >= 3) begin
      check("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", req_log[2], 32'h0000_0000);
    end
    check("wrap_pops", 32'(n_pop - n1 >= 3), 32'd1);

    // 6: misaligned redirect
    instr_ready = 1'b0;
    req_log.delete();
    n0 = n_req;
    redirect_to(32'h102);
`ifdef IFU_MISALIGN_FAULT_EN
    check("fault_valid", 32'(fault_valid), 32'd1);
    check("fault_pc", fault_pc, 32'h102);
    instr_ready = 1'b1;
    repeat (8) step();
    check("fault_no_req", 32'(n_req - n0), 32'd0);
    check("fault_no_instr", 32'(instr_valid), 32'd0);
    check("fault_sticky", 32'(fault_valid), 32'd1);
`else
    check("nofault_valid", 32'(fault_valid), 32'd0);
    check("nofault_pc", fault_pc, 32'h0);
    for (int i = 0; i < 30 && !instr_valid; i++) step();
    check("align_wait_valid", 32'(instr_valid), 32'd1);
    check("align_pc", instr_pc, 32'h100);
    check("align_instr", instruction, mem_word(32'h100));
    check("align_nreq", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check("align_req0", req_log[0], 32'h100);
    instr_ready = 1'b1;
    repeat (8) step();
`endif

    // Reset mid-operation takes effect without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_instruction", instruction, INSTR_NOP);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
